// File: rtl/reg_dump_seq_if.sv
// Beat stream from the register-dump sequencer to its debug/trace sink.
interface reg_dump_seq_if;
    logic [31:0] dout;
    logic [4:0]  dout_addr;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        dout_chk;

    modport master (
        output dout, dout_addr, dout_valid, dout_last, dout_chk,
        input  dout_ready
    );

    modport slave (
        input  dout, dout_addr, dout_valid, dout_last, dout_chk,
        output dout_ready
    );
endinterface

// File: rtl/reg_dump_seq.sv
// Register-file debug dump sequencer: walks FIRST_REG..LAST_REG through one read port.
// Define REG_DUMP_CHECKSUM_EN to append a modulo-2^32 checksum beat after the data beats.
module reg_dump_seq #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [4:0]         rf_addr,
    input  logic [31:0]        rf_data,
    output logic               busy,
    output logic               done,
    reg_dump_seq_if.master     dump
);
    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  ptr;
    logic [31:0] data_q;
    logic [4:0]  addr_q;
    logic        last_q;
    logic        hs;
    logic        at_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic        chk_q;
    logic [31:0] sum;
`endif

    assign hs      = (state == SEND) && dump.dout_ready;
    assign at_last = (ptr == LAST);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = SEND;
            SEND: if (hs) begin
                if (!at_last) state_nxt = READ;
`ifdef REG_DUMP_CHECKSUM_EN
                else if (!chk_q) state_nxt = SEND;
`endif
                else state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    // ptr only moves on entry to READ, so rf_addr naturally holds between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr    <= FIRST;
            data_q <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_q  <= 1'b0;
            sum    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr    <= FIRST;
                    last_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                    chk_q  <= 1'b0;
                    sum    <= '0;
`endif
                end
                READ: if (!abort) begin
                    data_q <= rf_data;
                    addr_q <= ptr;
`ifdef REG_DUMP_CHECKSUM_EN
                    last_q <= 1'b0;
                    chk_q  <= 1'b0;
                    sum    <= sum + rf_data;
`else
                    last_q <= at_last;
`endif
                end
                SEND: if (hs && !abort) begin
                    if (!at_last) begin
                        ptr <= ptr + 5'd1;
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    // checksum beat reuses SEND; READ is skipped
                    else if (!chk_q) begin
                        data_q <= sum;
                        addr_q <= '0;
                        last_q <= 1'b1;
                        chk_q  <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign rf_addr         = ptr;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign dump.dout_valid = (state == SEND);
    assign dump.dout       = data_q;
    assign dump.dout_addr  = addr_q;
    assign dump.dout_last  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    assign dump.dout_chk   = chk_q;
`else
    assign dump.dout_chk   = 1'b0;
`endif
endmodule
